// File: rtl/screen_fsm.sv
// -----------------------------------------------------------------------------
// screen_fsm
//
// Top-level screen sequencer for the game. Turns PS/2 make codes from the
// keyboard receiver into one-shot key events. Those events, together with the
// game-logic level inputs, drive a five-screen state machine:
// START, GAME, PAUSE, OVER and WIN.
//
// Parameters
//   KEY_START    make code that starts or resumes the game (Enter)
//   KEY_PAUSE    make code that toggles pause (Esc)
//   KEY_RESTART  make code that returns to the START screen (R)
//   HOLD_CYCLES  minimum number of clk cycles spent on an end screen (>= 1)
//   AUTO_RETURN  1: OVER/WIN fall back to START when the hold expires
//
// Ports
//   clk               system clock
//   rst               synchronous, active-high reset
//   i_keycode         last two PS/2 bytes received, {previous, current}
//   i_game_over       level input from game logic: player lost
//   i_level_done      level input from game logic: player won
//   o_screen          current screen (START=0 GAME=1 PAUSE=2 OVER=3 WIN=4)
//   o_screen_changed  one-cycle pulse in the first cycle of a new screen
//   o_new_game        one-cycle pulse in the first cycle of GAME entered
//                     from START
//   o_game_run        high while the screen is GAME
// -----------------------------------------------------------------------------
module screen_fsm #(
    parameter logic [7:0] KEY_START   = 8'h5A,
    parameter logic [7:0] KEY_PAUSE   = 8'h76,
    parameter logic [7:0] KEY_RESTART = 8'h2D,
    parameter int         HOLD_CYCLES = 65_000_000,
    parameter logic       AUTO_RETURN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_keycode,
    input  logic        i_game_over,
    input  logic        i_level_done,
    output logic [2:0]  o_screen,
    output logic        o_screen_changed,
    output logic        o_new_game,
    output logic        o_game_run
);

    localparam int            HW       = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

    typedef enum logic [2:0] {
        S_START = 3'd0,
        S_GAME  = 3'd1,
        S_PAUSE = 3'd2,
        S_OVER  = 3'd3,
        S_WIN   = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [15:0]    r_keycode_q;
    logic [HW-1:0]  r_hold;
    logic           r_screen_changed;
    logic           r_new_game;
    logic           w_hold_done;
    logic           w_end_screen;
    logic           w_start_ev;
    logic           w_pause_ev;
    logic           w_restart_ev;

    // An event fires only on the cycle the byte pair changes. Typematic
    // repeat leaves the pair untouched, and a break prefix {F0,K} is never
    // counted as a press.
    function automatic logic key_event(input logic [15:0] kc,
                                       input logic [15:0] kq,
                                       input logic [7:0]  key);
        return (kc != kq) && (kc[7:0] == key) && (kc[15:8] != 8'hF0);
    endfunction

    // Previous keycode. This register loads during reset as well, so a code
    // that is stable across reset release cannot look like a fresh press.
    always_ff @(posedge clk) begin
        r_keycode_q <= i_keycode;
    end

    assign w_start_ev   = key_event(i_keycode, r_keycode_q, KEY_START);
    assign w_pause_ev   = key_event(i_keycode, r_keycode_q, KEY_PAUSE);
    assign w_restart_ev = key_event(i_keycode, r_keycode_q, KEY_RESTART);
    assign w_end_screen = (r_state == S_OVER) || (r_state == S_WIN);
    assign w_hold_done  = (r_hold == HOLD_MAX);

    // End-screen hold counter. It is zero on the entry cycle and
    // saturates at HOLD_CYCLES.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
        end else if (w_end_screen) begin
            if (r_hold != HOLD_MAX) begin
                r_hold <= r_hold + HW'(1);
            end else begin
                r_hold <= r_hold;
            end
        end else begin
            r_hold <= '0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_START;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. In PAUSE, restart takes priority over resume.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_START: begin
                if (w_start_ev) begin
                    w_next = S_GAME;
                end else begin
                    w_next = S_START;
                end
            end
            S_GAME: begin
                if (i_game_over) begin
                    w_next = S_OVER;
                end else if (i_level_done) begin
                    w_next = S_WIN;
                end else if (w_pause_ev) begin
                    w_next = S_PAUSE;
                end else begin
                    w_next = S_GAME;
                end
            end
            S_PAUSE: begin
                if (w_restart_ev) begin
                    w_next = S_START;
                end else if (w_pause_ev || w_start_ev) begin
                    w_next = S_GAME;
                end else begin
                    w_next = S_PAUSE;
                end
            end
            S_OVER, S_WIN: begin
                if (w_hold_done && (AUTO_RETURN || w_start_ev || w_restart_ev)) begin
                    w_next = S_START;
                end else begin
                    w_next = r_state;
                end
            end
            default: begin
                w_next = S_START;
            end
        endcase
    end

    // Transition pulses. They are registered so that they coincide with
    // the first cycle of the new screen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_screen_changed <= 1'b0;
            r_new_game       <= 1'b0;
        end else begin
            r_screen_changed <= (w_next != r_state);
            r_new_game       <= (r_state == S_START) && (w_next == S_GAME);
        end
    end

    // Output decode of the state register.
    always_comb begin
        o_screen         = r_state;
        o_game_run       = (r_state == S_GAME);
        o_screen_changed = r_screen_changed;
        o_new_game       = r_new_game;
    end

endmodule

// File: tb/tb_screen_fsm.sv
module tb_screen_fsm;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] kc;
    logic        go;
    logic        ld;
    logic [2:0]  scr0, scr1;
    logic        chg0, chg1, ng0, ng1, run0, run1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    screen_fsm #(.HOLD_CYCLES(HOLD), .AUTO_RETURN(1'b0)) dut (
        .clk(clk), .rst(rst), .i_keycode(kc), .i_game_over(go), .i_level_done(ld),
        .o_screen(scr0), .o_screen_changed(chg0), .o_new_game(ng0), .o_game_run(run0));

    screen_fsm #(.HOLD_CYCLES(HOLD), .AUTO_RETURN(1'b1)) dut_ar (
        .clk(clk), .rst(rst), .i_keycode(kc), .i_game_over(go), .i_level_done(ld),
        .o_screen(scr1), .o_screen_changed(chg1), .o_new_game(ng1), .o_game_run(run1));

    typedef struct {
        logic        r;
        logic [15:0] k;
        logic        g;
        logic        l;
        logic [2:0]  s;
        logic        c;
        logic        n;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void add(input logic r, input logic [15:0] k, input logic g,
                                input logic l, input logic [2:0] s, input logic c,
                                input logic n);
        vec_t v;
        v.r = r; v.k = k; v.g = g; v.l = l; v.s = s; v.c = c; v.n = n;
        tbl.push_back(v);
    endfunction

    // Drive one cycle of inputs. Outputs are sampled 1 ns after the edge.
    task automatic step(input logic r, input logic [15:0] k, input logic g, input logic l);
        rst = r; kc = k; go = g; ld = l;
        @(posedge clk);
        #1;
    endtask

    // Reference model: screen codes plus cycles spent on the current screen.
    int          m_scr[2];
    int          m_tin[2];
    logic        m_chg[2];
    logic        m_ng[2];
    logic [15:0] m_prev;

    function automatic void model_step(input logic r, input logic [15:0] k,
                                       input logic g, input logic l);
        logic fresh, st, pa, re, hd;
        int   s, ns;
        fresh = (k != m_prev) && (k[15:8] != 8'hF0);
        st = fresh && (k[7:0] == 8'h5A);
        pa = fresh && (k[7:0] == 8'h76);
        re = fresh && (k[7:0] == 8'h2D);
        for (int a = 0; a < 2; a++) begin
            s  = m_scr[a];
            hd = (s == 3 || s == 4) && (m_tin[a] >= HOLD);
            ns = s;
            if (s == 0) begin
                if (st) ns = 1;
            end else if (s == 1) begin
                if (g) ns = 3;
                else if (l) ns = 4;
                else if (pa) ns = 2;
            end else if (s == 2) begin
                if (re) ns = 0;
                else if (pa || st) ns = 1;
            end else begin
                if (hd && (a == 1 || st || re)) ns = 0;
            end
            if (r) begin
                m_scr[a] = 0; m_tin[a] = 0; m_chg[a] = 1'b0; m_ng[a] = 1'b0;
            end else begin
                m_chg[a] = (ns != s);
                m_ng[a]  = (s == 0) && (ns == 1);
                m_tin[a] = (ns != s) ? 0 : m_tin[a] + 1;
                m_scr[a] = ns;
            end
        end
        m_prev = k;
    endfunction

    initial begin
        logic [7:0]  keys [4];
        logic [15:0] k;
        logic        r, g, l;
        int          sel;

        rst = 1'b1; kc = 16'h0000; go = 1'b0; ld = 1'b0;
        keys[0] = 8'h5A; keys[1] = 8'h76; keys[2] = 8'h2D; keys[3] = 8'h1C;

        // ---------------- table-driven directed vectors (AUTO_RETURN=0) -----
        add(1, 16'h0000, 0, 0, 3'd0, 0, 0);
        add(1, 16'h0000, 0, 0, 3'd0, 0, 0);
        add(0, 16'h005A, 0, 0, 3'd1, 1, 1);     // Enter -> GAME
        add(0, 16'h005A, 0, 0, 3'd1, 0, 0);     // pulses last one cycle
        add(0, 16'h5A76, 0, 0, 3'd2, 1, 0);     // Esc -> PAUSE
        for (int i = 0; i < 9; i++) add(0, 16'h5A76, 0, 0, 3'd2, 0, 0); // repeat
        add(0, 16'hF076, 0, 0, 3'd2, 0, 0);     // break: ignored
        add(0, 16'h7676, 0, 0, 3'd1, 1, 0);     // Esc again -> GAME, no new_game
        add(0, 16'h7676, 0, 0, 3'd1, 0, 0);
        add(0, 16'h0076, 1, 1, 3'd3, 1, 0);     // game_over beats level_done and pause
        add(0, 16'h0076, 0, 0, 3'd3, 0, 0);     // cycle e
        add(0, 16'h002D, 0, 0, 3'd3, 0, 0);     // e+1 restart ignored
        add(0, 16'hF02D, 0, 0, 3'd3, 0, 0);     // e+2
        add(0, 16'h002D, 0, 0, 3'd3, 0, 0);     // e+3 restart ignored
        add(0, 16'h2D2D, 0, 0, 3'd0, 1, 0);     // e+4 restart accepted -> START
        add(0, 16'h2D5A, 0, 0, 3'd1, 1, 1);
        add(0, 16'h5A76, 0, 0, 3'd2, 1, 0);
        add(0, 16'h2D2D, 0, 0, 3'd0, 1, 0);     // restart in PAUSE
        add(0, 16'h005A, 0, 0, 3'd1, 1, 1);
        add(0, 16'h005A, 1, 0, 3'd3, 1, 0);
        add(0, 16'h005A, 0, 0, 3'd3, 0, 0);
        add(0, 16'h005A, 0, 0, 3'd3, 0, 0);
        add(1, 16'h005A, 0, 0, 3'd0, 0, 0);     // reset mid-hold
        add(0, 16'h005A, 0, 0, 3'd0, 0, 0);     // stable code across release
        add(0, 16'h005A, 0, 0, 3'd0, 0, 0);
        add(0, 16'h015A, 0, 0, 3'd1, 1, 1);
        add(0, 16'h015A, 1, 0, 3'd3, 1, 0);
        for (int i = 0; i < 5; i++) add(0, 16'h015A, 1, 0, 3'd3, 0, 0); // held game_over
        add(0, 16'h025A, 1, 0, 3'd0, 1, 0);     // start after hold -> START
        add(0, 16'h035A, 1, 0, 3'd1, 1, 1);
        add(0, 16'h035A, 1, 0, 3'd3, 1, 0);     // game_over sampled again

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].k, tbl[i].g, tbl[i].l);
            chk($sformatf("tbl%0d_screen", i), {13'd0, scr0}, {13'd0, tbl[i].s});
            chk($sformatf("tbl%0d_changed", i), {15'd0, chg0}, {15'd0, tbl[i].c});
            chk($sformatf("tbl%0d_new_game", i), {15'd0, ng0}, {15'd0, tbl[i].n});
            chk($sformatf("tbl%0d_game_run", i), {15'd0, run0}, {15'd0, (tbl[i].s == 3'd1)});
        end

        // ---------------- AUTO_RETURN sequence -------------------------------
        step(1, 16'h0000, 0, 0);
        step(0, 16'h005A, 0, 0);
        chk("ar_game", {13'd0, scr1}, 16'd1);
        step(0, 16'h005A, 0, 1);                // level_done -> WIN, cycle e
        chk("ar_win_entry", {13'd0, scr1}, 16'd4);
        chk("ar_win_pulse", {15'd0, chg1}, 16'd1);
        for (int k2 = 1; k2 <= 5; k2++) begin
            step(0, 16'h005A, 0, 0);
            chk($sformatf("ar_e%0d_screen", k2), {13'd0, scr1}, (k2 == 5) ? 16'd0 : 16'd4);
            chk($sformatf("ar_e%0d_changed", k2), {15'd0, chg1}, (k2 == 5) ? 16'd1 : 16'd0);
        end
        chk("noar_stays_win", {13'd0, scr0}, 16'd4);

        // ---------------- randomized run against the model --------------------
        k = kc;
        m_prev = k;
        for (int a = 0; a < 2; a++) begin
            m_scr[a] = 0; m_tin[a] = 0; m_chg[a] = 1'b0; m_ng[a] = 1'b0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            sel = $urandom_range(0, 9);
            if (sel >= 5 && sel <= 7) k = {k[7:0], keys[$urandom_range(0, 3)]};
            else if (sel == 8) k = {8'hF0, k[7:0]};
            else if (sel == 9) k = {keys[$urandom_range(0, 3)], keys[$urandom_range(0, 3)]};
            r = (cyc == 0) || ($urandom_range(0, 199) == 0);
            g = ($urandom_range(0, 15) == 0);
            l = ($urandom_range(0, 15) == 0);
            model_step(r, k, g, l);
            step(r, k, g, l);
            chk("rnd_screen0", {13'd0, scr0}, 16'(m_scr[0]));
            chk("rnd_changed0", {15'd0, chg0}, {15'd0, m_chg[0]});
            chk("rnd_new_game0", {15'd0, ng0}, {15'd0, m_ng[0]});
            chk("rnd_game_run0", {15'd0, run0}, {15'd0, (m_scr[0] == 1)});
            chk("rnd_screen1", {13'd0, scr1}, 16'(m_scr[1]));
            chk("rnd_changed1", {15'd0, chg1}, {15'd0, m_chg[1]});
            chk("rnd_new_game1", {15'd0, ng1}, {15'd0, m_ng[1]});
            chk("rnd_game_run1", {15'd0, run1}, {15'd0, (m_scr[1] == 1)});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
